// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Optional build feature: MEM_ARB_STARVE_GUARD_EN (fetch starvation guard).
package mem_arb_pkg;

    // Owner of the read whose data returns on the next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_DM   = 2'b10
    } mem_own_t;

    // The arbiter always presents word-sized accesses; sub-word stores use the byte/half strobes.
    localparam logic [1:0] MEM_ACCESS_WORD = 2'b00;

    // Consecutive DM-won cycles tolerated before fetch is forced through.
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of cycles in which a live fetch request lost to DM.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic if_req,
    input  logic dm_req,
    input  logic flush,
    input  logic if_gnt,
    output logic starve_hit
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    // Next count: clear once fetch is served, withdrawn or flushed; otherwise saturate upward while DM keeps winning.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt || !if_req || flush) begin
            starve_cnt_d = '0;
        end else if (dm_req && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + ONE;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_hit = (starve_cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch (IF) and the data stage (DM).
// DM has priority; IF is cancelled by flush. Read data returns one cycle after the grant
// and is steered to the requester recorded in the owner register.
// Optional build feature: MEM_ARB_STARVE_GUARD_EN forces IF through after STARVE_LIMIT losses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h8002_0000,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_rw,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic        dm_byte,
    input  logic        dm_half,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    input  logic        flush,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    output logic        mem_dm_byte,
    output logic        mem_dm_half,
    output logic        mem_rw,
    output logic        mem_enable,
    input  logic [31:0] mem_data_out
);

    logic     if_live_s;
    logic     starve_hit_s;
    mem_own_t pend_own_q;
    mem_own_t pend_own_d;

    assign if_live_s = if_req & ~flush;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clock     (clock),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .dm_req    (dm_req),
        .flush     (flush),
        .if_gnt    (if_gnt),
        .starve_hit(starve_hit_s)
    );
`else
    assign starve_hit_s = 1'b0;
`endif

    // Grant selection; grants are suppressed while reset is asserted so memory sees no access.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!reset_n) begin
            if_gnt = 1'b0;
            dm_gnt = 1'b0;
        end else if (if_live_s && starve_hit_s) begin
            if_gnt = 1'b1;
        end else if (dm_req) begin
            dm_gnt = 1'b1;
        end else if (if_live_s) begin
            if_gnt = 1'b1;
        end else begin
            if_gnt = 1'b0;
            dm_gnt = 1'b0;
        end
    end

    // Memory-side mux: the winner's fields go to memory, everything is zero when idle.
    always_comb begin
        mem_address     = 32'h0000_0000;
        mem_data_in     = 32'h0000_0000;
        mem_access_size = MEM_ACCESS_WORD;
        mem_dm_byte     = 1'b0;
        mem_dm_half     = 1'b0;
        mem_rw          = 1'b0;
        case ({if_gnt, dm_gnt})
            2'b10: begin
                mem_address = if_addr;
                mem_rw      = 1'b1;
            end
            2'b01: begin
                mem_address = dm_addr;
                mem_data_in = dm_wdata;
                mem_dm_byte = dm_byte;
                mem_dm_half = dm_half;
                mem_rw      = dm_rw;
            end
            default: begin
                mem_address = 32'h0000_0000;
            end
        endcase
    end

    assign mem_enable = if_gnt | dm_gnt;

    // Record who owns the read issued this cycle; stores and idle cycles leave no owner.
    always_comb begin
        pend_own_d = OWN_NONE;
        if (if_gnt) begin
            pend_own_d = OWN_IF;
        end else if (dm_gnt && dm_rw) begin
            pend_own_d = OWN_DM;
        end else begin
            pend_own_d = OWN_NONE;
        end
    end

    // Owner register; reset drops any read in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_own_q <= OWN_NONE;
        end else begin
            pend_own_q <= pend_own_d;
        end
    end

    // A flush discards a fetch return that lands in the same cycle.
    assign if_rvalid = (pend_own_q == OWN_IF) & ~flush;
    assign dm_rvalid = (pend_own_q == OWN_DM);
    assign if_rdata  = mem_data_out;
    assign dm_rdata  = mem_data_out;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single unified `memory` instance between two requesters:
  - instruction fetch (IF): read-only, word accesses;
  - data memory stage (DM): loads and stores of byte, half or word.
- Issues at most one access per cycle.
- Tracks the owner of each in-flight read and steers the returned data back to that owner.
- Sits between the fetch/memory pipeline stages and `memory`. Handles branch flushes and optional starvation protection for fetch.

## Interface
Parameters:
- `BASE_ADDR`, 32'h80020000: memory window base; used only for bench address generation.
- `STARVE_LIMIT`, 4: consecutive cycles IF may be denied by DM before it is forced through. Used only with the guard macro.

Ports:
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `if_req`  in  1: fetch request.
- `if_addr`  in  32: fetch word address.
- `if_gnt`  out  1: fetch accepted this cycle.
- `if_rvalid`  out  1: fetch data valid.
- `if_rdata`  out  32: fetch data.
- `dm_req`  in  1: data request.
- `dm_rw`  in  1: 1 = load, 0 = store (memory polarity).
- `dm_addr`  in  32: data address.
- `dm_wdata`  in  32: store data.
- `dm_byte`, `dm_half`  in  1 each: store width; both 0 = word.
- `dm_gnt`  out  1: data request accepted.
- `dm_rvalid`  out  1: load data valid.
- `dm_rdata`  out  32: load data.
- `flush`  in  1: branch taken; cancels fetch traffic.
- `mem_address`  out  32, `mem_data_in`  out  32: to memory.
- `mem_access_size`  out  2, `mem_dm_byte`  out  1, `mem_dm_half`  out  1: to memory.
- `mem_rw`  out  1, `mem_enable`  out  1: to memory.
- `mem_data_out`  in  32: from memory.

## Operation
Arbitration is combinational each cycle:
- DM wins if `dm_req`.
- Otherwise IF wins if `if_req & ~flush`.
- `flush` forces `if_gnt=0` regardless of winner.
- Exactly one of `if_gnt`/`dm_gnt` is high, or neither. `mem_enable` = `if_gnt | dm_gnt`.

Memory drive:
- Granted requester's fields are muxed onto `mem_*`.
- `mem_access_size` is always 2'b00.
- IF grant drives `mem_rw=1`, `mem_dm_byte=0`, `mem_dm_half=0`, `mem_data_in=0`.
- No grant drives all `mem_*` to 0.

Read tracking:
- Owner register `pend_own` ∈ {NONE, IF, DM} is loaded each edge:
  - IF on `if_gnt`;
  - DM on `dm_gnt & dm_rw`;
  - else NONE.
- Stores never set a pending owner.
- `if_rvalid` = (`pend_own`==IF) & ~`flush`. `dm_rvalid` = (`pend_own`==DM).
- `if_rdata` and `dm_rdata` both pass through `mem_data_out`. They are meaningful only when the matching rvalid is high.

Boundary conditions:
- Simultaneous IF and DM requests: DM granted, IF stalls holding its request.
- Flush in the same cycle as an IF return: data dropped, `if_rvalid=0`.
- A flush never affects DM traffic.
- Back-to-back grants are allowed every cycle. A new issue overlaps the previous read's return.
- Reset mid-operation: `pend_own` cleared, so a read in flight returns no valid.

## Timing
- Grant latency 0: grant in the same cycle as the request when the requester wins.
- Read latency 1: grant in cycle N gives rvalid/rdata in cycle N+1.
- Store completes at the edge ending the grant cycle.
- Requesters hold `*_req` and fields stable until `*_gnt` is seen.
- Reset values (while `reset_n`=0):
  - `if_gnt=0`, `dm_gnt=0`, `if_rvalid=0`, `dm_rvalid=0`.
  - `mem_enable=0`, all other `mem_*` = 0.
  - `pend_own`=NONE, starvation counter 0.
  - `if_rdata` and `dm_rdata` pass through `mem_data_out` and are don't-care while their rvalid is 0.
- Gating `mem_enable` to 0 during reset means the memory performs no access.

## Configuration
Macro: `MEM_ARB_STARVE_GUARD_EN`.
- Defined:
  - Counter `starve_cnt`, width $clog2(STARVE_LIMIT+1), increments on cycles with `if_req & ~flush & dm_req`.
  - Saturates at `STARVE_LIMIT`.
  - Clears on `if_gnt`, on `~if_req`, or on `flush`.
  - When `starve_cnt==STARVE_LIMIT` and `if_req & ~flush`, IF wins over DM that cycle.
- Undefined: strict DM priority, no counter logic.

## Structure
- Package `mem_arb_pkg`:
  - owner enum `mem_own_t` {OWN_NONE, OWN_IF, OWN_DM};
  - `MEM_ACCESS_WORD = 2'b00`;
  - default `STARVE_LIMIT`.
- Sub-module `mem_arb_starve_ctr`: the saturating starvation counter. Instantiated only under the macro; outputs `starve_hit`.

## Test plan
- IF read at 32'h80020000 alone, memory preloaded with 32'h24080005:
  - `if_gnt=1` in cycle 0;
  - cycle 1: `if_rvalid=1`, `if_rdata=32'h24080005`;
  - `dm_rvalid=0`.
- IF and DM load at 32'h80020100 in the same cycle: `dm_gnt=1`, `if_gnt=0`; next cycle `dm_rvalid=1`; IF granted the following cycle.
- DM byte store of 32'h000000AB to 32'h80020203, then IF read at 32'h80020200: `if_rdata[7:0]=8'hAB`. Store cycle gives `mem_dm_byte=1`, `mem_rw=0`, no rvalid the next cycle.
- IF granted in cycle N, `flush=1` in cycle N+1: `if_rvalid=0` in N+1 and `if_gnt=0` in N+1.
- With `MEM_ARB_STARVE_GUARD_EN`, `STARVE_LIMIT=4`, DM requests every cycle and IF requests continuously: IF is denied for 4 cycles, then `if_gnt=1` on the 5th.
- Without the macro, the same stimulus gives IF never granted.
- `reset_n` dropped with a DM load in flight: `dm_rvalid=0` and `mem_enable=0` immediately (async); after release, all outputs stay 0 until a new request.
